pixel_pack_fifo: RTL and testbench

//  Pixel buffer between the ADC controller and the imager APB interface.

---
 rtl/pixel_pack_fifo.sv | 111 +++++++++++
 tb/tb_pixel_pack_fifo.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pack_fifo.sv
// pixel_pack_fifo: packs 8-bit ADC samples little-endian into 32-bit words
// and buffers them in a DEPTH-word FIFO with registered reads and
// empty / almost-full / full / sticky-overflow flags.
// Optional feature macro: PIXEL_PACK_FLUSH_EN (adds the flush port, which
// pushes a zero-padded partial word).
module pixel_pack_fifo #(
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter int AFULL_THRESH = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
`ifdef PIXEL_PACK_FLUSH_EN
  input  logic        flush,
`endif
  output logic [31:0] rd_data,
  output logic        data_valid,
  output logic        empty,
  output logic        afull,
  output logic        full,
  output logic        overflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AFULL = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [23:0]       pack_reg, pack_reg_next;
  logic [1:0]        pack_idx, pack_idx_next;
  logic [2:0]        idx_after;
  logic [31:0]       pack_word;
  logic              pop, room, wr_acc, push, drop;

  // Decide this cycle's pop, byte acceptance, word push and next packer state.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pop       = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    room      = !full || pop;
    wr_acc    = wr_en && room;
    drop      = wr_en && !room;
    pack_word = {8'h00, pack_reg};
    if (wr_acc) pack_word[{pack_idx, 3'b000} +: 8] = wr_data;
    idx_after     = {1'b0, pack_idx} + {2'b00, wr_acc};
    push          = (idx_after == 3'd4);
    pack_idx_next = idx_after[1:0];
    // Cleared on push so a later flush pads with zeros, not stale bytes.
    pack_reg_next = push ? 24'h0 : pack_word[23:0];
`ifdef PIXEL_PACK_FLUSH_EN
    // Flush of a partial word: bytes above the packed ones are already zero.
    if (flush && idx_after != 3'd0 && !push) begin
      push          = room;
      drop          = drop || !room;
      pack_idx_next = 2'd0;
      pack_reg_next = 24'h0;
    end
`endif
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Control state, registered flags and the registered read port.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pack_reg   <= '0;
      pack_idx   <= '0;
      empty      <= 1'b1;
      afull      <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      data_valid <= 1'b0;
      rd_data    <= '0;
    end else begin
      count      <= count_next;
      empty      <= (count_next == '0);
      afull      <= (count_next >= CNT_AFULL);
      full       <= (count_next == CNT_DEPTH);
      pack_reg   <= pack_reg_next;
      pack_idx   <= pack_idx_next;
      data_valid <= pop;
      if (drop) overflow <= 1'b1;
      if (push) wr_ptr   <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // Word storage; on a simultaneous push/pop at the same slot the read sees the old word.
  // NOTE: the memory array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pack_word;
  end

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// tb_pixel_pack_fifo: randomized and directed tests of pixel_pack_fifo
// against a queue-based reference model. Define PIXEL_PACK_FLUSH_EN to
// also exercise the flush feature.
module tb_pixel_pack_fifo;

  localparam int DEPTH = 256;
  localparam int AFULL = 192;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
`ifdef PIXEL_PACK_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] rd_data;
  logic        data_valid, empty, afull, full, overflow;

  pixel_pack_fifo #(.DEPTH(DEPTH), .ADDR_W(8), .AFULL_THRESH(AFULL)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
`ifdef PIXEL_PACK_FLUSH_EN
    .flush      (flush),
`endif
    .rd_data    (rd_data),
    .data_valid (data_valid),
    .empty      (empty),
    .afull      (afull),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: stored words, bytes waiting to form a word, outputs.
  logic [31:0] mq[$];
  logic [7:0]  mb[$];
  logic [31:0] exp_rd;
  logic        exp_dv, exp_ovf;
  logic [4:0]  exp_flags;  // {data_valid, empty, afull, full, overflow}
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic model_flags();
    exp_flags = {exp_dv, mq.size() == 0, mq.size() >= AFULL, mq.size() == DEPTH, exp_ovf};
  endtask

  task automatic model_reset();
    mq.delete();
    mb.delete();
    exp_rd  = '0;
    exp_dv  = 1'b0;
    exp_ovf = 1'b0;
    model_flags();
  endtask

  // One clock edge of the FIFO as the behaviour rules describe it.
  task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic f);
    bit was_full, popped, room;
    logic [31:0] wd;
    was_full = (mq.size() == DEPTH);
    popped   = r && (mq.size() != 0);
    room     = !was_full || popped;
    exp_dv   = popped;
    if (popped) exp_rd = mq.pop_front();
    if (w) begin
      if (room) begin
        mb.push_back(d);
        if (mb.size() == 4) begin
          mq.push_back({mb[3], mb[2], mb[1], mb[0]});
          mb.delete();
        end
      end else begin
        exp_ovf = 1'b1;
      end
    end
`ifdef PIXEL_PACK_FLUSH_EN
    if (f && mb.size() != 0) begin
      wd = '0;
      foreach (mb[i]) wd[i*8 +: 8] = mb[i];
      if (room) mq.push_back(wd);
      else exp_ovf = 1'b1;
      mb.delete();
    end
`else
    wd = {31'h0, f};  // flush is not a feature of this build
`endif
    model_flags();
  endtask

  // Apply one cycle of inputs, advance the model, settle past the edge.
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
`ifdef PIXEL_PACK_FLUSH_EN
    flush   = f;
`endif
    @(posedge clk);
    model_step(w, d, r, f);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
`ifdef PIXEL_PACK_FLUSH_EN
    flush   = 1'b0;
`endif
    model_reset();
    #12;
    tests_run++;
    if ({data_valid, empty, afull, full, overflow} !== 5'b01000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want %b", {data_valid, empty, afull, full, overflow}, 5'b01000);
    end
    tests_run++;
    if (rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rd_data: got %h want 00000000", rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    drive(1, 8'h01, 0, 0);
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h03, 0, 0);
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_partial_empty: got %b want 1", empty);
    end
    drive(1, 8'h04, 0, 0);
    tests_run++;
    if (empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_word_empty: got %b want 0", empty);
    end
    drive(0, 8'h00, 1, 0);
    tests_run++;
    if (data_valid !== 1'b1 || rd_data !== 32'h04030201 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_read: dv=%b data=%h empty=%b want dv=1 data=04030201 empty=1",
               data_valid, rd_data, empty);
    end
    drive(0, 8'h00, 0, 0);
    tests_run++;
    if (data_valid !== 1'b0 || rd_data !== 32'h04030201) begin
      tests_failed++;
      $display("FAIL basic_hold: dv=%b data=%h want dv=0 data=04030201", data_valid, rd_data);
    end
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1, 0);
      tests_run++;
      if (data_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 32'h04030201) begin
        tests_failed++;
        $display("FAIL empty_read[%0d]: dv=%b empty=%b data=%h want dv=0 empty=1 data=04030201",
                 i, data_valid, empty, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 8'h55, 0, 0);
    drive(1, 8'h66, 0, 0);
    drive(1, 8'h77, 0, 0);
    wr_en = 1'b0;
    #3 reset = 1'b1;  // between clock edges: reset must act at once
    model_reset();
    #1;
    tests_run++;
    if ({data_valid, empty, afull, full, overflow} !== 5'b01000 || rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_async: flags=%b data=%h want flags=01000 data=00000000",
               {data_valid, empty, afull, full, overflow}, rd_data);
    end
    #1 reset = 1'b0;
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    drive(1, 8'h33, 0, 0);
    drive(1, 8'h44, 0, 0);
    drive(0, 8'h00, 1, 0);
    tests_run++;
    if (data_valid !== 1'b1 || rd_data !== 32'h44332211 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_word: dv=%b data=%h empty=%b want dv=1 data=44332211 empty=1",
               data_valid, rd_data, empty);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    // Move the pointers off zero so the fill and drain cross the wrap.
    for (int i = 0; i < 100; i++) begin
      for (int b = 0; b < 4; b++) drive(1, 8'($urandom), 0, 0);
      drive(0, 8'h00, 1, 0);
    end
    for (int wd = 0; wd < DEPTH; wd++) begin
      for (int b = 0; b < 4; b++) drive(1, 8'($urandom), 0, 0);
      tests_run++;
      if ({data_valid, empty, afull, full, overflow} !== exp_flags) begin
        tests_failed++;
        $display("FAIL fill_flags[%0d]: got %b want %b", wd,
                 {data_valid, empty, afull, full, overflow}, exp_flags);
      end
    end
    drive(1, 8'hEE, 0, 0);
    tests_run++;
    if (full !== 1'b1 || overflow !== 1'b1 || afull !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_overflow: full=%b ovf=%b afull=%b want 1 1 1", full, overflow, afull);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1, 0);
      tests_run++;
      if (data_valid !== 1'b1 || rd_data !== exp_rd ||
          {data_valid, empty, afull, full, overflow} !== exp_flags) begin
        tests_failed++;
        $display("FAIL drain[%0d]: dv=%b data=%h flags=%b want dv=1 data=%h flags=%b", i,
                 data_valid, rd_data, {data_valid, empty, afull, full, overflow}, exp_rd, exp_flags);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_end: empty=%b ovf=%b want empty=1 ovf=1", empty, overflow);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] b;
    apply_reset();
    for (int i = 0; i < DEPTH * 4; i++) drive(1, 8'($urandom), 0, 0);
    // At full, a byte arriving together with a pop is accepted.
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      drive(1, b, (k == 0 || k == 3), 0);
      tests_run++;
      if ({data_valid, empty, afull, full, overflow} !== exp_flags ||
          (exp_dv && rd_data !== exp_rd)) begin
        tests_failed++;
        $display("FAIL push_pop[%0d]: flags=%b data=%h want flags=%b data=%h", k,
                 {data_valid, empty, afull, full, overflow}, rd_data, exp_flags, exp_rd);
      end
    end
    while (mq.size() != 0) begin
      drive(0, 8'h00, 1, 0);
      tests_run++;
      if (data_valid !== 1'b1 || rd_data !== exp_rd) begin
        tests_failed++;
        $display("FAIL push_pop_drain: dv=%b data=%h want dv=1 data=%h", data_valid, rd_data, exp_rd);
      end
    end
    tests_run++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL push_pop_end: empty=%b ovf=%b want empty=1 ovf=0", empty, overflow);
    end
  endtask

  task automatic test_random();
    logic w, r, f;
    apply_reset();
    for (int i = 0; i < 4200; i++) begin
      if ((i % 1400) < 1200) begin
        w = ($urandom_range(99, 0) < 90);
        r = ($urandom_range(99, 0) < 3);
      end else begin
        w = ($urandom_range(99, 0) < 10);
        r = ($urandom_range(99, 0) < 90);
      end
`ifdef PIXEL_PACK_FLUSH_EN
      f = ($urandom_range(99, 0) < 3);
`else
      f = 1'b0;
`endif
      drive(w, 8'($urandom), r, f);
      tests_run++;
      if ({data_valid, empty, afull, full, overflow} !== exp_flags ||
          (exp_dv && rd_data !== exp_rd)) begin
        tests_failed++;
        $display("FAIL random[%0d]: flags=%b data=%h want flags=%b data=%h", i,
                 {data_valid, empty, afull, full, overflow}, rd_data, exp_flags, exp_rd);
      end
    end
  endtask

`ifdef PIXEL_PACK_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    drive(0, 8'h00, 0, 1);
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_noop: empty=%b want 1", empty);
    end
    drive(1, 8'hAA, 0, 0);
    drive(1, 8'hBB, 0, 0);
    drive(0, 8'h00, 0, 1);
    drive(1, 8'hCC, 0, 1);  // byte packs first, then the flush applies
    drive(1, 8'h01, 0, 0);
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h03, 0, 0);
    drive(1, 8'h04, 0, 1);  // 4th byte pushes normally; flush does nothing
    drive(0, 8'h00, 1, 0);
    tests_run++;
    if (data_valid !== 1'b1 || rd_data !== 32'h0000BBAA) begin
      tests_failed++;
      $display("FAIL flush_two: dv=%b data=%h want dv=1 data=0000BBAA", data_valid, rd_data);
    end
    drive(0, 8'h00, 1, 0);
    tests_run++;
    if (data_valid !== 1'b1 || rd_data !== 32'h000000CC) begin
      tests_failed++;
      $display("FAIL flush_same_cycle: dv=%b data=%h want dv=1 data=000000CC", data_valid, rd_data);
    end
    drive(0, 8'h00, 1, 0);
    tests_run++;
    if (data_valid !== 1'b1 || rd_data !== 32'h04030201 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_full_word: dv=%b data=%h empty=%b want dv=1 data=04030201 empty=1",
               data_valid, rd_data, empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_reset_mid();
    test_fill();
    test_push_pop();
    test_random();
`ifdef PIXEL_PACK_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
